// File: rtl/sop_mac_sequencer_if.sv
// rtl/sop_mac_sequencer_if.sv - sample, result and coefficient signals of the SOP MAC sequencer
//
// Purpose: bundles the coefficient write port, the sample valid/ready input
// and the result valid/ready output of sop_mac_sequencer.
// Ports (signals):
//   coef_we/coef_addr/coef_data  coefficient write request
//   coef_err                     write dropped because the engine was busy
//   in_valid/in_ready/data_in    sample handshake
//   out_valid/out_ready/adder_out result handshake
//   busy                         engine is not idle
// Modports: master = sample/coef producer and result consumer, slave = engine.

interface sop_mac_sequencer_if #(
  parameter int width = 4,
  parameter int AW    = 2,
  parameter int ACC_W = 2*width+1+AW
);
  logic             coef_we;
  logic [AW-1:0]    coef_addr;
  logic [width:0]   coef_data;
  logic             coef_err;
  logic             in_valid;
  logic             in_ready;
  logic [width-1:0] data_in;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] adder_out;
  logic             busy;

  modport master (
    output coef_we, coef_addr, coef_data, in_valid, data_in, out_ready,
    input  coef_err, in_ready, out_valid, adder_out, busy
  );

  modport slave (
    input  coef_we, coef_addr, coef_data, in_valid, data_in, out_ready,
    output coef_err, in_ready, out_valid, adder_out, busy
  );
endinterface

// File: rtl/sop_mac_sequencer.sv
// rtl/sop_mac_sequencer.sv - time-multiplexed sum-of-products (FIR) engine
//
// Purpose: owns a TAPS-deep sample delay line and a writable coefficient bank,
// and computes sum(coef[k]*line[k]) with one shared multiplier/accumulator
// sequenced over TAPS cycles per accepted sample.
// Ports:
//   CLK    rising-edge clock
//   RESET  asynchronous active-low reset
//   bus    sop_mac_sequencer_if.slave (coefficient writes, sample in, result out)

module sop_mac_sequencer #(
  parameter int width = 4,
  parameter int AW    = 2,
  parameter int ACC_W = 2*width+1+AW
) (
  input  logic                  CLK,
  input  logic                  RESET,
  sop_mac_sequencer_if.slave    bus
);
  localparam int TAPS = 2**AW;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t            state;
  logic [width-1:0]  line [TAPS];
  logic [width:0]    coef [TAPS];
  logic [ACC_W-1:0]  acc;
  logic [AW-1:0]     idx;
  logic [2*width:0]  prod;
  logic [ACC_W-1:0]  acc_next;

  // Both operands widened to the full product width so the multiply is
  // evaluated at 2*width+1 bits.
  assign prod     = {{width{1'b0}}, coef[idx]} * {{(width+1){1'b0}}, line[idx]};
  assign acc_next = acc + ACC_W'(prod);

  assign bus.in_ready = (state == IDLE);
  assign bus.busy     = (state != IDLE);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state         <= IDLE;
      for (int k = 0; k < TAPS; k++) begin
        line[k] <= '0;
        coef[k] <= '0;
      end
      acc           <= '0;
      idx           <= '0;
      bus.adder_out <= '0;
      bus.out_valid <= 1'b0;
      bus.coef_err  <= 1'b0;
    end else begin
      bus.coef_err <= 1'b0;
      case (state)
        IDLE: begin
          // A write and an accept in the same cycle are both taken; the MAC
          // reads the bank only from the next cycle on, so it sees the new value.
          if (bus.coef_we) coef[bus.coef_addr] <= bus.coef_data;
          if (bus.in_valid) begin
            line[0] <= bus.data_in;
            for (int k = 1; k < TAPS; k++) line[k] <= line[k-1];
            acc   <= '0;
            idx   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          bus.coef_err <= bus.coef_we;
          acc          <= acc_next;
          idx          <= idx + AW'(1);
          if (idx == AW'(TAPS-1)) begin
            bus.adder_out <= acc_next;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          bus.coef_err <= bus.coef_we;
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sop_mac_sequencer.sv
// tb/tb_sop_mac_sequencer.sv - self-checking bench for sop_mac_sequencer

module tb_sop_mac_sequencer;
  localparam int W    = 4;
  localparam int AWP  = 2;
  localparam int NT   = 4;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  sop_mac_sequencer_if #(.width(W), .AW(AWP)) bus ();

  sop_mac_sequencer #(.width(W), .AW(AWP)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  // Reference model: a list of the last NT samples (newest first) and the bank.
  int m_line [NT];
  int m_coef [NT];

  function automatic int model_sum();
    int s = 0;
    for (int k = 0; k < NT; k++) s += m_coef[k] * m_line[k];
    return s;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < NT; k++) begin
      m_line[k] = 0;
      m_coef[k] = 0;
    end
  endfunction

  function automatic void model_accept(input int s);
    for (int k = NT-1; k > 0; k--) m_line[k] = m_line[k-1];
    m_line[0] = s;
  endfunction

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // All tasks start and end at #1 after a rising edge.
  task automatic do_reset();
    RESET = 1'b0;
    #2;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_adder_out", int'(bus.adder_out), 0);
    check("rst_in_ready",  int'(bus.in_ready), 1);
    check("rst_busy",      int'(bus.busy), 0);
    check("rst_coef_err",  int'(bus.coef_err), 0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    model_clear();
  endtask

  task automatic write_coef(input int addr, input int data);
    bus.coef_we   = 1'b1;
    bus.coef_addr = AWP'(addr);
    bus.coef_data = (W+1)'(data);
    @(posedge CLK); #1;
    bus.coef_we = 1'b0;
    check("idle_wr_no_err", int'(bus.coef_err), 0);
    m_coef[addr] = data;
  endtask

  int last_acc_cyc;
  int last_result;

  task automatic send(input int s, input int hold, input bit busy_wr);
    int n, lat, expv;
    bus.in_valid  = 1'b1;
    bus.data_in   = W'(s);
    bus.out_ready = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(posedge CLK); #1; n++; end
    check("in_ready_timeout", int'(n < 50), 1);
    @(posedge CLK); #1;
    last_acc_cyc = cyc;
    bus.in_valid = 1'b0;
    model_accept(s);
    expv = model_sum();
    if (busy_wr) begin
      bus.coef_we = 1'b1; bus.coef_addr = '0; bus.coef_data = 5'd7;
    end
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge CLK); #1;
      lat++;
      if (busy_wr && lat == 1) begin
        check("busy_wr_err_pulse", int'(bus.coef_err), 1);
        bus.coef_we = 1'b0;
      end else if (busy_wr && lat == 2) begin
        check("busy_wr_err_end", int'(bus.coef_err), 0);
      end
    end
    check("latency", lat, NT);
    check("result", int'(bus.adder_out), expv);
    check("done_busy", int'(bus.busy), 1);
    last_result = int'(bus.adder_out);
    if (hold > 0) begin
      bus.out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        bus.in_valid = (i % 2 == 0);
        bus.data_in  = 4'd9;
        @(posedge CLK); #1;
        check("bp_out_valid", int'(bus.out_valid), 1);
        check("bp_adder_out", int'(bus.adder_out), expv);
        check("bp_in_ready",  int'(bus.in_ready), 0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(posedge CLK); #1;
    check("hs_out_valid", int'(bus.out_valid), 0);
    check("hs_in_ready",  int'(bus.in_ready), 1);
    check("hs_adder_keep", int'(bus.adder_out), expv);
  endtask

  typedef struct {
    bit do_reset;
    bit do_load;
    int c [NT];
    int s;
    int expv;
    bit chk_space;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int prev_acc;
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
    bus.in_valid = 1'b0; bus.data_in = '0; bus.out_ready = 1'b1;

    vecs[0] = '{1'b1, 1'b1, '{1, 2, 3, 4},     5, 5,    1'b0};
    vecs[1] = '{1'b0, 1'b0, '{1, 2, 3, 4},     3, 13,   1'b1};
    vecs[2] = '{1'b1, 1'b1, '{31, 31, 31, 31}, 15, 465, 1'b0};
    vecs[3] = '{1'b0, 1'b0, '{31, 31, 31, 31}, 15, 930, 1'b1};
    vecs[4] = '{1'b0, 1'b0, '{31, 31, 31, 31}, 15, 1395, 1'b1};
    vecs[5] = '{1'b0, 1'b0, '{31, 31, 31, 31}, 15, 1860, 1'b1};
    vecs[6] = '{1'b0, 1'b1, '{1, 0, 0, 0},     7, 7,    1'b0};
    vecs[7] = '{1'b0, 1'b1, '{0, 0, 0, 1},     1, 15,   1'b0};

    // Reset then idle.
    repeat (2) @(posedge CLK);
    #1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      check("idle_in_ready", int'(bus.in_ready), 1);
      check("idle_coef_err", int'(bus.coef_err), 0);
    end
    check("idle_busy", int'(bus.busy), 0);
    check("idle_out_valid", int'(bus.out_valid), 0);

    // Table-driven vectors.
    prev_acc = 0;
    foreach (vecs[i]) begin
      if (vecs[i].do_reset) do_reset();
      if (vecs[i].do_load)
        for (int k = 0; k < NT; k++) write_coef(k, vecs[i].c[k]);
      send(vecs[i].s, 0, 1'b0);
      check($sformatf("vec%0d_value", i), last_result, vecs[i].expv);
      if (vecs[i].chk_space) check("accept_spacing", last_acc_cyc - prev_acc, NT + 2);
      prev_acc = last_acc_cyc;
    end

    // Backpressure with ignored in_valid pulses, then verify the pulsed
    // sample was not captured by the following result.
    for (int k = 0; k < NT; k++) write_coef(k, k + 1);
    send(2, 10, 1'b0);
    send(6, 0, 1'b0);

    // Busy write is dropped; the same write in idle lands on the next sample.
    send(4, 0, 1'b1);
    write_coef(0, 7);
    send(1, 0, 1'b0);

    // Reset during the second MAC cycle.
    bus.in_valid = 1'b1; bus.data_in = 4'd6;
    @(posedge CLK); #1;
    bus.in_valid = 1'b0;
    @(posedge CLK); #1;
    check("mid_mac_busy", int'(bus.busy), 1);
    RESET = 1'b0;
    #1;
    check("async_busy",      int'(bus.busy), 0);
    check("async_in_ready",  int'(bus.in_ready), 1);
    check("async_out_valid", int'(bus.out_valid), 0);
    check("async_adder_out", int'(bus.adder_out), 0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    model_clear();
    send(2, 0, 1'b0);
    check("post_rst_coef_zero", last_result, 0);
    for (int k = 0; k < NT; k++) write_coef(k, 1);
    send(9, 0, 1'b0);
    check("post_rst_line_zero", last_result, 11);
    write_coef(1, 0); write_coef(2, 0); write_coef(3, 0);
    send(9, 0, 1'b0);
    check("post_rst_nine", last_result, 9);

    // Randomized traffic against the model.
    for (int it = 0; it < 40; it++) begin
      int nw = $urandom_range(0, 2);
      for (int j = 0; j < nw; j++)
        write_coef($urandom_range(0, NT-1), $urandom_range(0, 31));
      send($urandom_range(0, 15), $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
